// File: rtl/timer_pwm_pkg.sv
// Shared encodings for the multi-channel timer/PWM engine.
package timer_pwm_pkg;

    // Channel operating modes (ch_mode field)
    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_PERIODIC   = 2'b01;
    localparam logic [1:0] MODE_PWM_EDGE   = 2'b10;
    localparam logic [1:0] MODE_PWM_CENTER = 2'b11;

    // Per-channel FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/timer_pwm_channel.sv
// One timer/PWM channel: prescaler, counter, shadow registers, IDLE/RUN state
// and registered outputs. Define TIMER_PWM_CENTER_EN to make mode 11
// center-aligned (up/down) PWM; otherwise mode 11 behaves as edge PWM.
module timer_pwm_channel
    import timer_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             pol,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] compare,
    input  logic             done_clr,
    output logic             pwm_out,
    output logic             done,
    output logic             irq,
    output logic             busy
);

    logic [0:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [PSC_W-1:0] psc_q,     psc_d;
    logic [1:0]       mode_sh_q, mode_sh_d;
    logic [CNT_W-1:0] per_sh_q,  per_sh_d;
    logic [CNT_W-1:0] cmp_sh_q,  cmp_sh_d;
    logic             pol_sh_q,  pol_sh_d;
    logic             done_q,    done_d;
    logic             irq_q,     irq_d;
    logic             pwm_q,     pwm_d;
`ifdef TIMER_PWM_CENTER_EN
    logic             dir_q,     dir_d;   // 0 counting up, 1 counting down
`endif
    logic [CNT_W-1:0] per_load;
    logic             tick;
    logic             wrap;

    // A zero period behaves as a period of one tick
    assign per_load = (period == '0) ? CNT_W'(1) : period;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            psc_q     <= '0;
            mode_sh_q <= MODE_ONESHOT;
            per_sh_q  <= '0;
            cmp_sh_q  <= '0;
            pol_sh_q  <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            pwm_q     <= 1'b0;
`ifdef TIMER_PWM_CENTER_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psc_q     <= psc_d;
            mode_sh_q <= mode_sh_d;
            per_sh_q  <= per_sh_d;
            cmp_sh_q  <= cmp_sh_d;
            pol_sh_q  <= pol_sh_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            pwm_q     <= pwm_d;
`ifdef TIMER_PWM_CENTER_EN
            dir_q     <= dir_d;
`endif
        end
    end

    // Next-state: disable beats start, start beats counting, wrap beats done_clr
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psc_d     = psc_q;
        mode_sh_d = mode_sh_q;
        per_sh_d  = per_sh_q;
        cmp_sh_d  = cmp_sh_q;
        pol_sh_d  = pol_sh_q;
        done_d    = done_q;
        irq_d     = 1'b0;
        tick      = 1'b0;
        wrap      = 1'b0;
`ifdef TIMER_PWM_CENTER_EN
        dir_d     = dir_q;
`endif
        if (done_clr) begin
            done_d = 1'b0;
        end

        // Output follows the counter value of the previous cycle
        pwm_d = pol_sh_q;
        if ((state_q == ST_RUN) && mode_sh_q[1]) begin
            pwm_d = (cnt_q < cmp_sh_q) ^ pol_sh_q;
        end

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            psc_d   = '0;
            pwm_d   = pol;
`ifdef TIMER_PWM_CENTER_EN
            dir_d   = 1'b0;
`endif
        end else if (start) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            psc_d     = '0;
            mode_sh_d = mode;
            per_sh_d  = per_load;
            cmp_sh_d  = compare;
            pol_sh_d  = pol;
            done_d    = 1'b0;
`ifdef TIMER_PWM_CENTER_EN
            dir_d     = 1'b0;
`endif
        end else if (state_q == ST_RUN) begin
            // >= keeps the prescaler bounded if psc is lowered mid-count
            tick  = (psc_q >= psc);
            psc_d = tick ? '0 : psc_q + PSC_W'(1);
            if (tick) begin
`ifdef TIMER_PWM_CENTER_EN
                if (mode_sh_q == MODE_PWM_CENTER) begin
                    if (!dir_q && (cnt_q != per_sh_q)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        dir_d = 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            dir_d = 1'b0;
                            wrap  = 1'b1;
                        end
                    end
                end else
`endif
                if (cnt_q == per_sh_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (wrap) begin
                    irq_d  = 1'b1;
                    done_d = 1'b1;
                    if (mode_sh_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                    end else begin
                        per_sh_d = per_load;
                        cmp_sh_d = compare;
                    end
                end
            end
        end
    end

    assign pwm_out = pwm_q;
    assign done    = done_q;
    assign irq     = irq_q;
    assign busy    = (state_q == ST_RUN);

endmodule

// File: rtl/timer_pwm_array.sv
// NUM_CH independent timer/PWM channels; this level only slices the buses.
// Optional feature macro: TIMER_PWM_CENTER_EN (center-aligned PWM in mode 11).
module timer_pwm_array
    import timer_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PSC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [2*NUM_CH-1:0]     ch_mode,
    input  logic [NUM_CH-1:0]       ch_pol,
    input  logic [PSC_W-1:0]        psc,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH*CNT_W-1:0] compare,
    input  logic [NUM_CH-1:0]       done_clr,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       irq,
    output logic [NUM_CH-1:0]       busy
);

    // One channel instance per bus slice
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_pwm_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (ch_en[i]),
            .start    (ch_start[i]),
            .mode     (ch_mode[2*i +: 2]),
            .pol      (ch_pol[i]),
            .psc      (psc),
            .period   (period[i*CNT_W +: CNT_W]),
            .compare  (compare[i*CNT_W +: CNT_W]),
            .done_clr (done_clr[i]),
            .pwm_out  (pwm_out[i]),
            .done     (done[i]),
            .irq      (irq[i]),
            .busy     (busy[i])
        );
    end

endmodule
